// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU operand selection, operand forwarding and load-use stall.
// Optional feature macro: FORWARD_EN (EX/MEM and MEM/WB forwarding); undefined = stall on any producer match.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [1:0]  id_op_kind,
    input  logic [2:0]  id_funct3,
    input  logic [6:0]  id_funct7,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic [4:0]  exmem_rd_addr,
    input  logic        exmem_reg_write,
    input  logic [31:0] exmem_result,
    input  logic [4:0]  memwb_rd_addr,
    input  logic        memwb_reg_write,
    input  logic [31:0] memwb_result,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [31:0] ex_data1,
    output logic [31:0] ex_data2,
    output logic [4:0]  ex_select,
    output logic [4:0]  ex_rd_addr,
    output logic        ex_reg_write,
    output logic        ex_mem_read
);

    localparam logic [1:0] KIND_OP_IMM = 2'b01;
    localparam logic [1:0] KIND_OP     = 2'b10;

    // Handshake: an instruction moves from ID into this stage on a rising edge where
    // id_valid & id_ready; it leaves on an edge where ex_valid & ex_ready. Neither side
    // may make valid depend on ready; flush and rst kill whatever would be captured.

    logic        valid_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic [31:0] rs1_data_q;
    logic [31:0] rs2_data_q;
    logic [31:0] imm_q;
    logic [4:0]  sel_q;
    logic        use_rs2_q;
    logic        reg_write_q;
    logic        mem_read_q;

    logic [4:0]  sel_d;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;
    logic        hazard;
    logic        capture;
    logic        hold;

    always_comb begin
        sel_d = 5'b00000;
        case (id_op_kind)
            KIND_OP:     sel_d = {id_funct3, id_funct7[5], id_funct7[0]};
            KIND_OP_IMM: sel_d = {id_funct3, (id_funct3 == 3'b101) & id_funct7[5], 1'b0};
            default:     sel_d = 5'b00000;
        endcase
    end

`ifdef FORWARD_EN
    // Youngest producer wins; x0 is never a forwarding source.
    function automatic logic [31:0] forward(input logic [4:0]  addr,
                                            input logic [31:0] stored,
                                            input logic        exmem_we,
                                            input logic [4:0]  exmem_rd,
                                            input logic [31:0] exmem_val,
                                            input logic        memwb_we,
                                            input logic [4:0]  memwb_rd,
                                            input logic [31:0] memwb_val);
        logic [31:0] res;
        res = stored;
        if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == addr))
            res = memwb_val;
        if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == addr))
            res = exmem_val;
        return res;
    endfunction

    assign rs1_fwd = forward(rs1_q, rs1_data_q, exmem_reg_write, exmem_rd_addr, exmem_result,
                             memwb_reg_write, memwb_rd_addr, memwb_result);
    assign rs2_fwd = forward(rs2_q, rs2_data_q, exmem_reg_write, exmem_rd_addr, exmem_result,
                             memwb_reg_write, memwb_rd_addr, memwb_result);

    // Only a load sitting here cannot be forwarded in time.
    assign hazard = valid_q & mem_read_q & (rd_q != 5'd0) &
                    ((rd_q == id_rs1_addr) |
                     ((id_op_kind == KIND_OP) & (rd_q == id_rs2_addr)));
`else
    function automatic logic rs_match(input logic       we,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2);
        return we && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

    assign rs1_fwd = rs1_data_q;
    assign rs2_fwd = rs2_data_q;

    // Without forwarding, any in-flight writer of a source register stalls ID.
    assign hazard = rs_match(valid_q & reg_write_q, rd_q, id_rs1_addr, id_rs2_addr) |
                    rs_match(exmem_reg_write, exmem_rd_addr, id_rs1_addr, id_rs2_addr) |
                    rs_match(memwb_reg_write, memwb_rd_addr, id_rs1_addr, id_rs2_addr);

    logic unused_nofwd;
    assign unused_nofwd = ^{exmem_result, memwb_result, rs1_q, rs2_q};
`endif

    logic unused_funct7;
    assign unused_funct7 = ^{id_funct7[6], id_funct7[4:1]};

    assign id_ready = (~valid_q | ex_ready) & ~hazard;
    assign capture  = id_valid & id_ready;
    assign hold     = valid_q & ~ex_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            sel_q       <= '0;
            use_rs2_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q     <= 1'b1;
            rs1_q       <= id_rs1_addr;
            rs2_q       <= id_rs2_addr;
            rd_q        <= id_rd_addr;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            sel_q       <= sel_d;
            use_rs2_q   <= (id_op_kind == KIND_OP);
            reg_write_q <= id_reg_write;
            mem_read_q  <= id_mem_read;
        end else if (hold) begin
            // Latch forwarded operands so they survive the producers retiring.
            rs1_data_q <= rs1_fwd;
            rs2_data_q <= rs2_fwd;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_data1     = valid_q ? rs1_fwd : 32'd0;
    assign ex_data2     = valid_q ? (use_rs2_q ? rs2_fwd : imm_q) : 32'd0;
    assign ex_select    = valid_q ? sel_q : 5'd0;
    assign ex_rd_addr   = rd_q;
    assign ex_reg_write = valid_q & reg_write_q;
    assign ex_mem_read  = valid_q & mem_read_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage
Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 id_valid  in  1  decoded instruction present.
REQ-004 id_ready  out  1  stage accepts; transfer when id_valid & id_ready.
REQ-005 id_rs1_addr  in  5  source register 1 index.
REQ-006 id_rs2_addr  in  5  source register 2 index.
REQ-007 id_rd_addr  in  5  destination register index.
REQ-008 id_rs1_data  in  32  register file read data 1.
REQ-009 id_rs2_data  in  32  register file read data 2.
REQ-010 id_imm  in  32  sign-extended immediate.
REQ-011 id_op_kind  in  2  00 force ADD (load/store), 01 OP-IMM, 10 OP, 11 reserved (treated as 00).
REQ-012 id_funct3  in  3  instruction funct3.
REQ-013 id_funct7  in  7  instruction funct7 / imm[11:5].
REQ-014 id_reg_write  in  1  instruction writes rd.
REQ-015 id_mem_read  in  1  instruction is a load.
REQ-016 exmem_rd_addr  in  5  EX/MEM destination.
REQ-017 exmem_reg_write  in  1  EX/MEM writes rd.
REQ-018 exmem_result  in  32  EX/MEM ALU result.
REQ-019 memwb_rd_addr  in  5  MEM/WB destination.
REQ-020 memwb_reg_write  in  1  MEM/WB writes rd.
REQ-021 memwb_result  in  32  MEM/WB writeback value.
REQ-022 flush  in  1  kill stage contents (branch redirect).
REQ-023 ex_ready  in  1  ALU/EX stage accepts this cycle.
REQ-024 ex_valid  out  1  stage holds a live instruction.
REQ-025 ex_data1  out  32  ALU DATA1 operand.
REQ-026 ex_data2  out  32  ALU DATA2 operand.
REQ-027 ex_select  out  5  ALU SELECT code.
REQ-028 ex_rd_addr  out  5  registered destination.
REQ-029 ex_reg_write  out  1  registered reg_write, gated by ex_valid.
REQ-030 ex_mem_read  out  1  registered mem_read, gated by ex_valid.
Function
REQ-031 Capture on id_valid & id_ready & !flush; fields registered, outputs visible next cycle (latency 1).
REQ-032 id_ready = (!ex_valid | ex_ready) & !hazard; if ex_ready & !capture, ex_valid clears next cycle (bubble).
REQ-033 ex_select = {funct3, f7b5, f7b0}: kind 10 -> f7b5=funct7[5], f7b0=funct7[0]; kind 01 -> f7b5=funct7[5] only if funct3=101, f7b0=0; kind 00 -> 00000.
REQ-034 ex_data1 = forwarded rs1; ex_data2 = id_imm (stored) when kind!=10, else forwarded rs2.
REQ-035 Forwarding: EX/MEM match (reg_write, rd!=0, rd==rs) beats MEM/WB match beats stored value; rd=0 never forwards.
REQ-036 Load-use hazard: ex_valid & ex_mem_read & ex_rd_addr!=0 & (==id_rs1_addr, or ==id_rs2_addr with kind 10) deasserts id_ready exactly until load leaves.
REQ-037 While ex_valid & !ex_ready, stored rs1/rs2 data SHALL be overwritten each cycle with current forwarded values so forwarding survives upstream stages draining.
REQ-038 flush: ex_valid=0 next cycle, overrides simultaneous capture and hold; ex_valid=0 forces ex_data1/ex_data2/ex_select/ex_reg_write/ex_mem_read to 0.
Reset
REQ-039 rst=1 at an edge: ex_valid=0, all stored fields 0, overrides flush and capture, including mid-hold or mid-hazard.
REQ-040 During and after reset until first capture: ex_data1=ex_data2=0, ex_select=0, id_ready=1.
Configuration
REQ-041 FORWARD_EN defined: REQ-035/REQ-037 forwarding and load-use hazard as specified.
REQ-042 FORWARD_EN undefined: no forwarding, stored register data used directly; hazard = any rs match (rd!=0, reg_write) against ex_rd_addr (ex_valid), exmem_rd_addr or memwb_rd_addr.
Verification
REQ-043 rst=1 two cycles, then 0 -> ex_valid=0, ex_data1=ex_data2=0, ex_select=00000, id_ready=1.
REQ-044 OP rs1=10 rs2=5 funct7=0x20 funct3=000, then OP-IMM imm=5 funct7 field 0x20 funct3=000 -> select 00010 data 10/5, then select 00000 data2=5; OP funct7=0x01 funct3=100 -> select 10001.
REQ-045 Stored rs1=0, exmem rd=3 result 0x12345678, memwb rd=3 result 0xDEAD -> ex_data1=0x12345678; exmem rd=0 -> 0xDEAD.
REQ-046 EX holds load rd=5, ID rs1=5 -> id_ready=0 one cycle, bubble (ex_valid=0), then capture with memwb forward 0xCAFE -> ex_data1=0xCAFE.
REQ-047 ex_ready=0 three cycles, memwb forwards 0x55 to rs2 then retires -> ex_data2 stays 0x55, id_ready=0; flush with id_valid=1 -> ex_valid=0 next cycle.
